// File: rtl/systemizer_seq_if.sv
// Host-side streams of the systemizer sequencer: matrix load in, systemized matrix out.
interface systemizer_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/systemizer_seq.sv
// Sequencer for the systemizer core: load matrix, start core, retry on fail,
// stream the systemized matrix back out through a 2-entry read FIFO.
module systemizer_seq #(
    parameter int N        = 4,
    parameter int M        = 3,
    parameter int L        = 16,
    parameter int K        = 24,
    parameter int MAX_TRY  = 4,
    localparam int E       = $clog2(M),
    localparam int W       = N * E,
    localparam int D       = L * K / N,
    localparam int A       = $clog2(D)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic            abort,
    output logic            busy,
    systemizer_seq_if.slave host,
    output logic            reload_req,
    output logic            result_ok,
    output logic            result_fail,
    output logic [3:0]      try_count,
    output logic            sys_start,
    input  logic            sys_done,
    input  logic            sys_fail,
    output logic            sys_wr_en,
    output logic [A-1:0]    sys_wr_addr,
    output logic [W-1:0]    sys_data_in,
    output logic            sys_rd_en,
    output logic [A-1:0]    sys_rd_addr,
    input  logic [W-1:0]    sys_data_out
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4,
        ST_RETRY  = 3'd5
    } state_t;

    localparam logic [A-1:0] LAST_ADDR = A'(D - 1);
    localparam logic [3:0]   MAX_TRY_V = 4'(MAX_TRY);

    state_t       state_r;
    state_t       state_s;
    logic [A-1:0] waddr_r;
    logic [A-1:0] raddr_r;
    logic [A-1:0] oaddr_r;
    logic         rd_all_r;
    logic         inflight_r;
    logic [1:0]   cnt_r;
    logic [W-1:0] fifo_r [2];
    logic         wp_r;
    logic         rp_r;
    logic [3:0]   try_r;
    logic         ok_r;
    logic         fail_r;
    logic         wr_fire_s;
    logic         rd_issue_s;
    logic         head_valid_s;
    logic         out_fire_s;
    logic         push_s;
    logic         pop_s;

    assign busy          = (state_r != ST_IDLE);
    assign host.in_ready = (state_r == ST_LOAD);
    assign wr_fire_s     = host.in_valid && host.in_ready;
    assign sys_wr_en     = wr_fire_s;
    assign sys_wr_addr   = waddr_r;
    assign sys_data_in   = wr_fire_s ? host.in_data : {W{1'b0}};
    assign sys_start     = (state_r == ST_START);
    assign reload_req    = (state_r == ST_RETRY);

    // A read is allowed only while FIFO entries plus the read in flight leave room.
    assign rd_issue_s    = (state_r == ST_UNLOAD) && !rd_all_r &&
                           ((3'(cnt_r) + 3'(inflight_r)) < 3'd2);
    assign sys_rd_en     = rd_issue_s;
    assign sys_rd_addr   = raddr_r;

    // The in-flight word is presented straight from the core when the FIFO is empty.
    assign head_valid_s   = (state_r == ST_UNLOAD) && ((cnt_r != 2'd0) || inflight_r);
    assign host.out_valid = head_valid_s;
    assign host.out_data  = !head_valid_s ? {W{1'b0}} :
                            (cnt_r != 2'd0) ? fifo_r[rp_r] : sys_data_out;
    assign out_fire_s     = head_valid_s && host.out_ready;
    assign push_s         = inflight_r && !(out_fire_s && (cnt_r == 2'd0));
    assign pop_s          = out_fire_s && (cnt_r != 2'd0);

    assign try_count   = try_r;
    assign result_ok   = ok_r;
    assign result_fail = fail_r;

    // Next-state selection; abort overrides every state.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   state_s = go ? ST_LOAD : ST_IDLE;
                ST_LOAD:   state_s = (wr_fire_s && (waddr_r == LAST_ADDR)) ? ST_START : ST_LOAD;
                ST_START:  state_s = ST_WAIT;
                ST_WAIT: begin
                    if (!sys_done) begin
                        state_s = ST_WAIT;
                    end else if (!sys_fail) begin
                        state_s = ST_UNLOAD;
                    end else if (try_r == MAX_TRY_V) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RETRY;
                    end
                end
                ST_RETRY:  state_s = ST_LOAD;
                ST_UNLOAD: state_s = (out_fire_s && (oaddr_r == LAST_ADDR)) ? ST_IDLE : ST_UNLOAD;
                default:   state_s = ST_IDLE;
            endcase
        end
    end

    // State register, attempt counter and registered result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            try_r   <= 4'd0;
            ok_r    <= 1'b0;
            fail_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_IDLE) && go && !abort) begin
                try_r <= 4'd0;
            end else if (state_r == ST_START) begin
                try_r <= try_r + 4'd1;
            end
            ok_r   <= !abort && out_fire_s && (oaddr_r == LAST_ADDR);
            fail_r <= abort || ((state_r == ST_WAIT) && sys_done && sys_fail && (try_r == MAX_TRY_V));
        end
    end

    // Write, read-issue and output address counters; all cleared on any state change.
    always_ff @(posedge clk) begin
        if (rst || (state_s != state_r)) begin
            waddr_r  <= {A{1'b0}};
            raddr_r  <= {A{1'b0}};
            oaddr_r  <= {A{1'b0}};
            rd_all_r <= 1'b0;
        end else begin
            if (wr_fire_s) begin
                waddr_r <= waddr_r + 1'b1;
            end
            if (rd_issue_s) begin
                if (raddr_r == LAST_ADDR) begin
                    rd_all_r <= 1'b1;
                end else begin
                    raddr_r <= raddr_r + 1'b1;
                end
            end
            if (out_fire_s) begin
                oaddr_r <= oaddr_r + 1'b1;
            end
        end
    end

    // Read pipeline and 2-entry output FIFO, flushed whenever UNLOAD is not next.
    always_ff @(posedge clk) begin
        if (rst || (state_s != ST_UNLOAD)) begin
            inflight_r <= 1'b0;
            cnt_r      <= 2'd0;
            wp_r       <= 1'b0;
            rp_r       <= 1'b0;
        end else begin
            inflight_r <= rd_issue_s;
            if (push_s) begin
                fifo_r[wp_r] <= sys_data_out;
                wp_r         <= ~wp_r;
            end
            if (pop_s) begin
                rp_r <= ~rp_r;
            end
            cnt_r <= cnt_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end
endmodule
